// File: rtl/bcd_entry_to_bin.sv
// Decimal digit-entry front end: shifts BCD digits in from the switches and, on commit,
// folds them into a binary value one digit per clock, most significant digit first.
module bcd_entry_to_bin #(
   parameter int DIGITS = 4,
   parameter int WIDTH  = 14
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [3:0]            digit_in,
   input  logic                  digit_stb,
   input  logic                  clear,
   input  logic                  commit,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic [2:0]            digit_count,
   output logic                  busy,
   output logic [WIDTH-1:0]      value_out,
   output logic                  value_valid,
   output logic                  error
);

   localparam int          BCD_W     = 4 * DIGITS;
   localparam int          IDX_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
   localparam logic [2:0]  MAX_COUNT = 3'(DIGITS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

   typedef enum logic {
      IDLE,
      CONV
   } state_t;

   state_t            state;
   logic [WIDTH-1:0]  acc;
   logic [IDX_W-1:0]  idx;
   logic [3:0]        cur_digit;
   logic [WIDTH-1:0]  next_acc;

   // Horner step: acc*10 built from two shifts, plus the digit selected by idx.
   always_comb begin
      cur_digit = bcd_out[4*idx +: 4];
      next_acc  = (acc << 3) + (acc << 1) + WIDTH'(cur_digit);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         acc         <= '0;
         idx         <= '0;
         bcd_out     <= '0;
         digit_count <= '0;
         busy        <= 1'b0;
         value_out   <= '0;
         value_valid <= 1'b0;
         error       <= 1'b0;
      end else begin
         value_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (clear) begin
                  bcd_out     <= '0;
                  digit_count <= '0;
                  error       <= 1'b0;
               end else if (commit) begin
                  acc   <= '0;
                  idx   <= LAST_IDX;
                  busy  <= 1'b1;
                  state <= CONV;
               end else if (digit_stb && (digit_count < MAX_COUNT)) begin
                  // A full entry swallows further strobes silently, even non-BCD ones.
                  if (digit_in > 4'd9) begin
                     error <= 1'b1;
                  end else begin
                     bcd_out     <= (bcd_out << 4) | BCD_W'(digit_in);
                     digit_count <= digit_count + 3'd1;
                  end
               end
            end
            CONV: begin
               acc <= next_acc;
               idx <= idx - IDX_W'(1);
               if (idx == '0) begin
                  value_out   <= next_acc;
                  value_valid <= 1'b1;
                  busy        <= 1'b0;
                  bcd_out     <= '0;
                  digit_count <= '0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bcd_entry_to_bin.sv
// Randomized bench for bcd_entry_to_bin: a digit-list model predicts the entry state each edge
// and queues expected conversion results, which a monitor pops whenever value_valid is seen.
module tb_bcd_entry_to_bin;

   localparam int DIGITS = 4;
   localparam int WIDTH  = 14;

   logic                 clk;
   logic                 rst;
   logic [3:0]           digit_in;
   logic                 digit_stb;
   logic                 clear;
   logic                 commit;
   logic [4*DIGITS-1:0]  bcd_out;
   logic [2:0]           digit_count;
   logic                 busy;
   logic [WIDTH-1:0]     value_out;
   logic                 value_valid;
   logic                 error;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   int  digits[$];
   int  sb[$];
   bit  m_error;
   int  busy_cnt;
   int  pending;
   int  last_value;
   bit  exp_valid;

   bcd_entry_to_bin #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
      .clk         (clk),
      .rst         (rst),
      .digit_in    (digit_in),
      .digit_stb   (digit_stb),
      .clear       (clear),
      .commit      (commit),
      .bcd_out     (bcd_out),
      .digit_count (digit_count),
      .busy        (busy),
      .value_out   (value_out),
      .value_valid (value_valid),
      .error       (error)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog actual=timeout required=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic chk(input string name, input longint actual, input longint expected);
      checks++;
      if (actual != expected) begin
         failures++;
         $display("[TB] FAIL %s actual=%0d required=%0d", name, actual, expected);
      end
   endtask

   function automatic int decimal_value();
      int v = 0;
      foreach (digits[i]) v = v * 10 + digits[i];
      return v;
   endfunction

   function automatic longint expected_bcd();
      longint v = 0;
      foreach (digits[i]) v = v * 16 + digits[i];
      return v;
   endfunction

   task automatic model_reset();
      digits.delete();
      sb.delete();
      m_error    = 0;
      busy_cnt   = 0;
      pending    = 0;
      last_value = 0;
      exp_valid  = 0;
   endtask

   task automatic model_edge(input bit stb, input int d, input bit clr, input bit cmt);
      exp_valid = 0;
      if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) begin
            digits.delete();
            last_value = pending;
            exp_valid  = 1;
         end
      end else if (clr) begin
         digits.delete();
         m_error = 0;
      end else if (cmt) begin
         pending  = decimal_value();
         sb.push_back(pending);
         busy_cnt = DIGITS;
      end else if (stb && digits.size() < DIGITS) begin
         if (d > 9) m_error = 1;
         else digits.push_back(d);
      end
   endtask

   task automatic check_output();
      chk("bcd_out",     longint'(bcd_out),     expected_bcd());
      chk("digit_count", longint'(digit_count), longint'(digits.size()));
      chk("busy",        longint'(busy),        longint'(busy_cnt > 0));
      chk("error",       longint'(error),       longint'(m_error));
      chk("value_valid", longint'(value_valid), longint'(exp_valid));
      chk("value_out",   longint'(value_out),   longint'(last_value));
   endtask

   task automatic apply_stimulus(input bit stb, input int d, input bit clr, input bit cmt);
      @(negedge clk);
      digit_stb = stb;
      digit_in  = 4'(d);
      clear     = clr;
      commit    = cmt;
      @(posedge clk);
      model_edge(stb, d, clr, cmt);
      #1;
      digit_stb = 1'b0;
      clear     = 1'b0;
      commit    = 1'b0;
      check_output();
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) apply_stimulus(0, 0, 0, 0);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_bcd_out"},     longint'(bcd_out),     0);
      chk({tag, "_digit_count"}, longint'(digit_count), 0);
      chk({tag, "_busy"},        longint'(busy),        0);
      chk({tag, "_value_out"},   longint'(value_out),   0);
      chk({tag, "_value_valid"}, longint'(value_valid), 0);
      chk({tag, "_error"},       longint'(error),       0);
   endtask

   // Monitor: every presented result must match the oldest outstanding commit.
   always @(negedge clk) begin
      if (rst && value_valid) begin
         if (sb.size() == 0) begin
            chk("spurious_value_valid", 1, 0);
         end else begin
            chk("scoreboard_value", longint'(value_out), longint'(sb.pop_front()));
         end
      end
   end

   initial begin
      rst       = 1'b0;
      digit_in  = 4'd0;
      digit_stb = 1'b0;
      clear     = 1'b0;
      commit    = 1'b0;
      model_reset();
      #12;
      check_all_zero("reset");
      @(negedge clk);
      rst = 1'b1;

      // Nominal entry
      apply_stimulus(1, 1, 0, 0);
      apply_stimulus(1, 2, 0, 0);
      apply_stimulus(1, 3, 0, 0);
      apply_stimulus(1, 4, 0, 0);
      chk("nominal_bcd", longint'(bcd_out), 64'h1234);
      chk("nominal_count", longint'(digit_count), 4);
      apply_stimulus(0, 0, 0, 1);
      idle_cycles(4);
      chk("nominal_value", longint'(value_out), 1234);
      idle_cycles(1);

      // Short entry, then empty commit straight after
      apply_stimulus(1, 7, 0, 0);
      chk("short_bcd", longint'(bcd_out), 64'h0007);
      apply_stimulus(0, 0, 0, 1);
      idle_cycles(4);
      chk("short_value", longint'(value_out), 7);
      apply_stimulus(0, 0, 0, 1);
      idle_cycles(4);
      chk("empty_value", longint'(value_out), 0);

      // Invalid digit and clear
      apply_stimulus(1, 5, 0, 0);
      apply_stimulus(1, 10, 0, 0);
      chk("invalid_bcd", longint'(bcd_out), 64'h0005);
      chk("invalid_error", longint'(error), 1);
      apply_stimulus(0, 0, 1, 0);
      chk("clear_error", longint'(error), 0);

      // Full entry with an extra digit, then all three events at once
      apply_stimulus(1, 9, 0, 0);
      apply_stimulus(1, 9, 0, 0);
      apply_stimulus(1, 9, 0, 0);
      apply_stimulus(1, 9, 0, 0);
      apply_stimulus(1, 5, 0, 0);
      apply_stimulus(0, 0, 0, 1);
      idle_cycles(4);
      chk("full_value", longint'(value_out), 9999);
      apply_stimulus(1, 6, 0, 0);
      apply_stimulus(1, 3, 1, 1);
      chk("simul_busy", longint'(busy), 0);
      chk("simul_count", longint'(digit_count), 0);

      // Busy lockout
      apply_stimulus(1, 4, 0, 0);
      apply_stimulus(1, 2, 0, 0);
      apply_stimulus(0, 0, 0, 1);
      apply_stimulus(1, 3, 0, 0);
      apply_stimulus(0, 0, 0, 1);
      apply_stimulus(0, 0, 1, 0);
      idle_cycles(1);
      chk("lockout_value", longint'(value_out), 42);
      idle_cycles(3);

      // Reset mid-conversion
      apply_stimulus(1, 1, 0, 0);
      apply_stimulus(1, 2, 0, 0);
      apply_stimulus(1, 3, 0, 0);
      apply_stimulus(1, 4, 0, 0);
      apply_stimulus(0, 0, 0, 1);
      idle_cycles(2);
      #2;
      rst = 1'b0;
      #1;
      check_all_zero("midreset");
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      idle_cycles(5);
      apply_stimulus(1, 8, 0, 0);
      chk("post_reset_bcd", longint'(bcd_out), 64'h0008);
      apply_stimulus(0, 0, 1, 0);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int r;
         int d;
         r = int'($urandom_range(0, 99));
         d = int'($urandom_range(0, 9));
         if (r < 10 && digits.size() < DIGITS) d = int'($urandom_range(10, 15));
         if (r < 55)      apply_stimulus(1, d, 0, 0);
         else if (r < 65) apply_stimulus(0, d, 0, 1);
         else if (r < 70) apply_stimulus(0, d, 1, 0);
         else if (r < 74) apply_stimulus(1, d, 1, 1);
         else             apply_stimulus(0, d, 0, 0);
      end
      idle_cycles(DIGITS + 2);
      chk("scoreboard_drained", longint'(sb.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
